// File: rtl/keypad_encoder.sv
// rtl/keypad_encoder.sv - 4x4 matrix keypad scanner with debounce and valid/ready key code output
//
// Ports:
//   JM1222HM_clk    : single clock
//   JM1222HM_rst_n  : asynchronous active-low reset
//   JM1222HM_col_n  : column sense, active-low, asynchronous to clk
//   JM1222HM_ready  : consumer accepts the code while valid is high
//   JM1222HM_row_n  : row drive, active-low one-hot
//   JM1222HM_key    : key code = 4*row + col, stable while valid
//   JM1222HM_valid  : key holds a code not yet accepted
//   JM1222HM_held   : a confirmed key is down until its release is confirmed
module keypad_encoder #(
    parameter int SCAN_DIV = 1000,
    parameter int DEBOUNCE = 8
) (
    input  logic       JM1222HM_clk,
    input  logic       JM1222HM_rst_n,
    input  logic [3:0] JM1222HM_col_n,
    input  logic       JM1222HM_ready,
    output logic [3:0] JM1222HM_row_n,
    output logic [3:0] JM1222HM_key,
    output logic       JM1222HM_valid,
    output logic       JM1222HM_held
);

    localparam int CW = $clog2(SCAN_DIV);
    localparam int MW = $clog2(DEBOUNCE + 1);
    localparam logic [CW-1:0] DIV_LAST   = CW'(SCAN_DIV - 1);
    localparam logic [MW-1:0] MATCH_DONE = MW'(DEBOUNCE);

    typedef enum logic [1:0] {
        ST_SCAN,
        ST_DEBOUNCE,
        ST_HELD,
        ST_RELEASE
    } state_t;

    state_t        state;
    logic [3:0]    col_meta;
    logic [3:0]    col_s;
    logic [CW-1:0] div_cnt;
    logic [1:0]    row_idx;
    logic [1:0]    cand;
    logic [MW-1:0] match;
    logic          tick;
    logic          active;
    logic [1:0]    det_col;
    logic [MW-1:0] match_inc;

    // Two-flop synchronizer; idles high so reset looks like "no key".
    always_ff @(posedge JM1222HM_clk or negedge JM1222HM_rst_n) begin
        if (!JM1222HM_rst_n) begin
            col_meta <= 4'b1111;
            col_s    <= 4'b1111;
        end else begin
            col_meta <= JM1222HM_col_n;
            col_s    <= col_meta;
        end
    end

    // Row dwell counter; the last count of each dwell is the sampling tick.
    always_ff @(posedge JM1222HM_clk or negedge JM1222HM_rst_n) begin
        if (!JM1222HM_rst_n) begin
            div_cnt <= '0;
        end else if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + CW'(1);
        end
    end

    assign tick      = (div_cnt == DIV_LAST);
    assign active    = ~&col_s;
    assign match_inc = match + MW'(1);

    // Lowest-index pressed column wins; the value is ignored when inactive.
    always_comb begin
        det_col = 2'd3;
        if (!col_s[0]) begin
            det_col = 2'd0;
        end else if (!col_s[1]) begin
            det_col = 2'd1;
        end else if (!col_s[2]) begin
            det_col = 2'd2;
        end
    end

    always_ff @(posedge JM1222HM_clk or negedge JM1222HM_rst_n) begin
        if (!JM1222HM_rst_n) begin
            state          <= ST_SCAN;
            JM1222HM_row_n <= 4'b1110;
            row_idx        <= 2'd0;
            cand           <= 2'd0;
            match          <= '0;
            JM1222HM_key   <= 4'd0;
            JM1222HM_valid <= 1'b0;
            JM1222HM_held  <= 1'b0;
        end else begin
            // Acceptance is independent of the scan state. Confirmation only
            // happens with valid low, so it never races this clear.
            if (JM1222HM_valid && JM1222HM_ready) begin
                JM1222HM_valid <= 1'b0;
            end

            if (tick) begin
                case (state)
                    ST_SCAN: begin
                        // A pending code blocks new presses so key stays stable.
                        if (active && !JM1222HM_valid) begin
                            cand  <= det_col;
                            match <= MW'(1);
                            state <= ST_DEBOUNCE;
                        end else begin
                            JM1222HM_row_n <= {JM1222HM_row_n[2:0], JM1222HM_row_n[3]};
                            row_idx        <= row_idx + 2'd1;
                        end
                    end
                    ST_DEBOUNCE: begin
                        if (!active) begin
                            state          <= ST_SCAN;
                            JM1222HM_row_n <= {JM1222HM_row_n[2:0], JM1222HM_row_n[3]};
                            row_idx        <= row_idx + 2'd1;
                        end else if (det_col == cand) begin
                            if (match_inc == MATCH_DONE) begin
                                JM1222HM_key   <= {row_idx, cand};
                                JM1222HM_valid <= 1'b1;
                                JM1222HM_held  <= 1'b1;
                                state          <= ST_HELD;
                            end else begin
                                match <= match_inc;
                            end
                        end else begin
                            cand  <= det_col;
                            match <= MW'(1);
                        end
                    end
                    ST_HELD: begin
                        // Any column of the frozen row keeps the key held.
                        if (!active) begin
                            match <= MW'(1);
                            state <= ST_RELEASE;
                        end
                    end
                    ST_RELEASE: begin
                        if (active) begin
                            state <= ST_HELD;
                        end else if (match_inc == MATCH_DONE) begin
                            JM1222HM_held  <= 1'b0;
                            state          <= ST_SCAN;
                            JM1222HM_row_n <= {JM1222HM_row_n[2:0], JM1222HM_row_n[3]};
                            row_idx        <= row_idx + 2'd1;
                        end else begin
                            match <= match_inc;
                        end
                    end
                    default: state <= ST_SCAN;
                endcase
            end
        end
    end

endmodule

// File: doc/keypad_encoder.md
# keypad_encoder

- Scans a 4x4 matrix keypad, debounces presses and releases, and encodes each accepted press as a 4-bit key code.
- It is the input-side counterpart of the calculator's 4-bit-to-segment display decoders: it produces the 4-bit values those decoders consume.
- Codes are delivered over a valid/ready handshake to the calculator datapath, one code per physical press, with no auto-repeat.

## Interface

Parameters:
- SCAN_DIV, default 1000: clock cycles per row dwell. Must be ≥ 4, so synchronized columns settle before sampling.
- DEBOUNCE, default 8: number of consecutive matching samples needed to confirm a press or a release. Must be ≥ 2.

Ports:
- JM1222HM_clk, input, 1: the single clock.
- JM1222HM_rst_n, input, 1: asynchronous, active-low reset.
- JM1222HM_col_n, input, 4: keypad column sense, active-low, asynchronous to the clock.
- JM1222HM_ready, input, 1: consumer accepts the code when it is high while valid is high.
- JM1222HM_row_n, output, 4: row drive, active-low one-hot.
- JM1222HM_key, output, 4: key code, equal to 4*row + col.
- JM1222HM_valid, output, 1: key holds a code that has not yet been accepted.
- JM1222HM_held, output, 1: a confirmed key is currently down, from confirmation until its release is confirmed.

## Operation

- **Column synchronizer:** col_n passes through a 2-flop synchronizer. All decisions use the synchronized value, called colS below.
- **Tick counter:** counts 0..SCAN_DIV-1 and wraps. A "tick" is the cycle where the count equals SCAN_DIV-1. colS is sampled only on ticks.
- **Column priority:** a sample is "active" when any colS bit is low. The lowest-index low bit is the detected column. Higher-index columns pressed at the same time are ignored.

FSM states are SCAN, DEBOUNCE, HELD and RELEASE.
- **SCAN**
  - Tick with an inactive sample, or with valid=1: row_n rotates 1110 → 1101 → 1011 → 0111 → 1110.
  - Tick with an active sample and valid=0: latch the candidate column, set match count to 1, go to DEBOUNCE. The row stays frozen.
- **DEBOUNCE**
  - Tick, same detected column: increment the count.
  - When the count reaches DEBOUNCE: load key = {row index, column}, set valid=1 and held=1, go to HELD.
  - Tick, different active column: adopt it as the new candidate and set the count to 1.
  - Tick, inactive sample: return to SCAN and advance the row.
- **HELD**
  - Tick, inactive sample: set count to 1, go to RELEASE.
  - Any active sample on a tick, including a different column of the same row: stay in HELD.
- **RELEASE**
  - Tick, inactive sample: increment the count.
  - When the count reaches DEBOUNCE: held=0, go to SCAN and advance the row.
  - Tick, active sample: return to HELD.
- **Handshake**
  - valid clears on any cycle with valid=1 and ready=1.
  - key is stable while valid=1.
  - valid is independent of the FSM state. A release completing before acceptance does not drop the code.
  - A new press is not confirmed while valid=1, because SCAN will not enter DEBOUNCE.
- Rows other than the frozen row are not observed while in DEBOUNCE, HELD or RELEASE.

## Timing

- **Reset values (asynchronous):** row_n=1110, key=0000, valid=0, held=0, state=SCAN, tick counter=0, synchronizer flops=1111.
- **Reset mid-operation** (including during HELD with valid=1): all outputs return to the reset values immediately. The pending code is discarded.
- **Row change:** occurs on the clock edge ending a tick cycle. The first sample of the new row is taken SCAN_DIV cycles later.
- **Press latency:** valid and key update on the edge ending the DEBOUNCE-th matching tick. The first matching tick is the one where SCAN detected the key. Total latency is (DEBOUNCE-1)*SCAN_DIV cycles after the detection tick, plus the time for the scan to reach that row and the 2 synchronizer cycles.
- **Acceptance:** valid falls on the edge following the first cycle with valid&ready. A consumer holding ready=1 sees valid high for exactly one cycle.
- **Release:** held falls, and scanning resumes, on the edge ending the DEBOUNCE-th consecutive inactive tick.
- **Simultaneous events:** valid&ready in the same cycle as a confirmation edge cannot occur, since confirmation requires valid=0. A release confirmed in the same cycle as acceptance applies both updates.

## Test plan

All scenarios use SCAN_DIV=4 and DEBOUNCE=3.
1. **Reset:** assert rst_n=0 mid-cycle → row_n=1110, key=0, valid=0 and held=0 asynchronously. Release reset with no keys → row_n cycles 1110, 1101, 1011, 0111, one step every 4 cycles.
2. **Clean press:** hold row 2 / column 1 down with ready=1 → key=9 (4'b1001), valid high for 1 cycle, held=1. Release → held=0 after 3 inactive ticks, and row_n resumes from 0111.
3. **Bounce rejection:** row 1 / column 0 low for 1 sample, high for the next → no valid, and scanning resumes. A later stable press → key=4.
4. **Backpressure:** ready=0, press and release row 3 / column 3 → valid stays 1 and key=15 through the release and held=0. Pressing row 0 / column 2 meanwhile produces no new code. Raise ready → valid falls next cycle.
5. **Column priority:** row 0 / columns 1 and 3 pressed together → key=1, and only one code is produced until both keys are released.
6. **Reset in HELD:** assert rst_n=0 while valid=1 and held=1 → valid=0, held=0, key=0 and row_n=1110 immediately. After reset, with the key still down → a fresh debounce, then the same code reappears.
